// File: rtl/rv_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_pipe_ctrl
// Brief    : uRV pipeline sequencing controller. Turns hazard, redirect and
//            busy conditions into per-stage stall/kill strobes and keeps a
//            saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module rv_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic        x_load_hazard_i,
  input  logic        x_branch_taken_i,
  input  logic        x_mc_start_i,
  input  logic        x_mc_done_i,
  input  logic        w_dm_busy_i,
  input  logic        stall_count_clr_i,
  output logic        f_stall_o,
  output logic        d_stall_o,
  output logic        x_stall_o,
  output logic        d_kill_o,
  output logic        x_kill_o,
  output logic        f_redirect_o,
  output logic [2:0]  state_o,
  output logic [31:0] stall_count_o
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    BUBBLE   = 3'd1,
    FLUSH    = 3'd2,
    MC_WAIT  = 3'd3,
    MEM_WAIT = 3'd4
  } state_t;

  // Counter preload leaves FLUSH after the remaining FLUSH_CYCLES-1 cycles,
  // since the redirect cycle itself is the first kill cycle.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  flush_cnt;
  logic [2:0]  flush_cnt_nxt;
  logic [31:0] stall_count;

  logic f_stall;
  logic d_stall;
  logic x_stall;
  logic d_kill;
  logic x_kill;
  logic redirect;

  // Mealy strobe decode and next-state selection
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    f_stall       = 1'b0;
    d_stall       = 1'b0;
    x_stall       = 1'b0;
    d_kill        = 1'b0;
    x_kill        = 1'b0;
    redirect      = 1'b0;
    case (state)
      RUN: begin
        if (w_dm_busy_i) begin
          f_stall   = 1'b1;
          d_stall   = 1'b1;
          x_stall   = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (x_valid_i && x_mc_start_i) begin
          f_stall   = 1'b1;
          d_stall   = 1'b1;
          x_stall   = 1'b1;
          state_nxt = MC_WAIT;
        end else if (x_valid_i && x_branch_taken_i) begin
          redirect = 1'b1;
          d_kill   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end
        end else if (x_valid_i && x_load_hazard_i) begin
          f_stall   = 1'b1;
          d_stall   = 1'b1;
          x_kill    = 1'b1;
          state_nxt = BUBBLE;
        end
      end
      BUBBLE: begin
        // Hazard flag is stale here because decode was held last cycle
        if (w_dm_busy_i) begin
          f_stall   = 1'b1;
          d_stall   = 1'b1;
          x_stall   = 1'b1;
          state_nxt = MEM_WAIT;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        // Branches are ignored: the instruction in X is being killed
        d_kill = 1'b1;
        if (w_dm_busy_i) begin
          f_stall = 1'b1;
          d_stall = 1'b1;
          x_stall = 1'b1;
        end else if (flush_cnt <= 3'd1) begin
          flush_cnt_nxt = 3'd0;
          state_nxt     = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
        end
      end
      MC_WAIT: begin
        if (!x_mc_done_i || w_dm_busy_i) begin
          f_stall = 1'b1;
          d_stall = 1'b1;
          x_stall = 1'b1;
        end
        if (x_mc_done_i) begin
          state_nxt = w_dm_busy_i ? MEM_WAIT : RUN;
        end
      end
      MEM_WAIT: begin
        if (w_dm_busy_i) begin
          f_stall = 1'b1;
          d_stall = 1'b1;
          x_stall = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = 3'd0;
      end
    endcase
  end

  // State and flush counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Saturating stall-cycle counter; clear wins over increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_count <= 32'd0;
    end else if (stall_count_clr_i) begin
      stall_count <= 32'd0;
    end else if (f_stall_o && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  // Strobes are gated by reset so nothing leaks out while rst_n_i is low
  assign f_stall_o     = rst_n_i & f_stall;
  assign d_stall_o     = rst_n_i & d_stall;
  assign x_stall_o     = rst_n_i & x_stall;
  assign d_kill_o      = rst_n_i & d_kill;
  assign x_kill_o      = rst_n_i & x_kill;
  assign f_redirect_o  = rst_n_i & redirect;
  assign state_o       = state;
  assign stall_count_o = stall_count;

endmodule
`default_nettype wire

// File: tb/tb_rv_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_pipe_ctrl
// Brief    : Scoreboard bench for rv_pipe_ctrl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_pipe_ctrl;

  logic        clk_i;
  logic        rst_n_i;
  logic        x_valid_i;
  logic        x_load_hazard_i;
  logic        x_branch_taken_i;
  logic        x_mc_start_i;
  logic        x_mc_done_i;
  logic        w_dm_busy_i;
  logic        stall_count_clr_i;
  logic        f_stall_o;
  logic        d_stall_o;
  logic        x_stall_o;
  logic        d_kill_o;
  logic        x_kill_o;
  logic        f_redirect_o;
  logic [2:0]  state_o;
  logic [31:0] stall_count_o;

  rv_pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .x_valid_i         (x_valid_i),
    .x_load_hazard_i   (x_load_hazard_i),
    .x_branch_taken_i  (x_branch_taken_i),
    .x_mc_start_i      (x_mc_start_i),
    .x_mc_done_i       (x_mc_done_i),
    .w_dm_busy_i       (w_dm_busy_i),
    .stall_count_clr_i (stall_count_clr_i),
    .f_stall_o         (f_stall_o),
    .d_stall_o         (d_stall_o),
    .x_stall_o         (x_stall_o),
    .d_kill_o          (d_kill_o),
    .x_kill_o          (x_kill_o),
    .f_redirect_o      (f_redirect_o),
    .state_o           (state_o),
    .stall_count_o     (stall_count_o)
  );

  // Expected strobes are packed {f_stall, d_stall, x_stall, d_kill, x_kill, redirect}
  typedef struct {
    string       name;
    logic [5:0]  s;
    logic [2:0]  st;
    logic [31:0] c;
  } exp_t;

  exp_t q[$];
  int   n_total;
  int   n_pass;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Apply one cycle of inputs at the falling edge and queue its expectation.
  // Input vector is {valid, load_hazard, branch_taken, mc_start, mc_done, dm_busy, clr}.
  task automatic step(input string nm, input logic rn, input logic [6:0] in,
                      input logic [5:0] s, input logic [2:0] st, input logic [31:0] c);
    exp_t e;
    @(negedge clk_i);
    rst_n_i = rn;
    {x_valid_i, x_load_hazard_i, x_branch_taken_i, x_mc_start_i,
     x_mc_done_i, w_dm_busy_i, stall_count_clr_i} = in;
    e.name = nm;
    e.s    = s;
    e.st   = st;
    e.c    = c;
    q.push_back(e);
  endtask

  // Monitor: sample just before the rising edge and compare against the queue head
  initial begin
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clk_i);
      #4;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {f_stall_o, d_stall_o, x_stall_o, d_kill_o, x_kill_o, f_redirect_o};
        n_total++;
        if (act == e.s && state_o == e.st && stall_count_o == e.c) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got strobes=%b state=%0d count=%h, want strobes=%b state=%0d count=%h",
                   e.name, act, state_o, stall_count_o, e.s, e.st, e.c);
        end
      end
    end
  end

  initial begin
    n_total           = 0;
    n_pass            = 0;
    rst_n_i           = 1'b1;
    x_valid_i         = 1'b0;
    x_load_hazard_i   = 1'b0;
    x_branch_taken_i  = 1'b0;
    x_mc_start_i      = 1'b0;
    x_mc_done_i       = 1'b0;
    w_dm_busy_i       = 1'b0;
    stall_count_clr_i = 1'b0;

    // Reset with active inputs: strobes must be gated off
    step("reset",   1'b0, 7'b1011010, 6'b000000, 3'd0, 32'd0);
    step("idle",    1'b1, 7'b0000000, 6'b000000, 3'd0, 32'd0);
    // Load hazard: one stall + kill, then bubble
    step("lh0",     1'b1, 7'b1100000, 6'b110010, 3'd0, 32'd0);
    step("lh1",     1'b1, 7'b1100000, 6'b000000, 3'd1, 32'd1);
    step("lh2",     1'b1, 7'b0000000, 6'b000000, 3'd0, 32'd1);
    // Taken branch: redirect once, two kill cycles, second branch ignored
    step("br0",     1'b1, 7'b1010000, 6'b000101, 3'd0, 32'd1);
    step("br1",     1'b1, 7'b1010000, 6'b000100, 3'd2, 32'd1);
    step("br2clr",  1'b1, 7'b0000001, 6'b000000, 3'd0, 32'd1);
    // Multi-cycle op: start at cycle 0, done at cycle 5
    step("mc0",     1'b1, 7'b1001000, 6'b111000, 3'd0, 32'd0);
    step("mc1",     1'b1, 7'b0000000, 6'b111000, 3'd3, 32'd1);
    step("mc2",     1'b1, 7'b0000000, 6'b111000, 3'd3, 32'd2);
    step("mc3",     1'b1, 7'b0000000, 6'b111000, 3'd3, 32'd3);
    step("mc4",     1'b1, 7'b0000000, 6'b111000, 3'd3, 32'd4);
    step("mc5done", 1'b1, 7'b0000100, 6'b000000, 3'd3, 32'd5);
    step("mc6",     1'b1, 7'b0000000, 6'b000000, 3'd0, 32'd5);
    // Busy + branch + hazard together; branch taken after busy drops
    step("sim0",    1'b1, 7'b1110010, 6'b111000, 3'd0, 32'd5);
    step("sim1",    1'b1, 7'b1110010, 6'b111000, 3'd4, 32'd6);
    step("sim2",    1'b1, 7'b1110010, 6'b111000, 3'd4, 32'd7);
    step("sim3",    1'b1, 7'b1010000, 6'b000000, 3'd4, 32'd8);
    step("sim4br",  1'b1, 7'b1010000, 6'b000101, 3'd0, 32'd8);
    step("flbusy",  1'b1, 7'b0000010, 6'b111100, 3'd2, 32'd8);
    step("flend",   1'b1, 7'b0000000, 6'b000100, 3'd2, 32'd9);
    step("flrun",   1'b1, 7'b0000000, 6'b000000, 3'd0, 32'd9);
    // MC done while memory busy moves to MEM_WAIT
    step("mcm0",    1'b1, 7'b1001000, 6'b111000, 3'd0, 32'd9);
    step("mcm1",    1'b1, 7'b0000110, 6'b111000, 3'd3, 32'd10);
    step("mcm2",    1'b1, 7'b0000010, 6'b111000, 3'd4, 32'd11);
    step("mcm3",    1'b1, 7'b0000000, 6'b000000, 3'd4, 32'd12);
    // Busy in BUBBLE behaves as MEM, stale hazard ignored
    step("bub0",    1'b1, 7'b1100000, 6'b110010, 3'd0, 32'd12);
    step("bub1",    1'b1, 7'b1100010, 6'b111000, 3'd1, 32'd13);
    step("bub2",    1'b1, 7'b0000000, 6'b000000, 3'd4, 32'd14);
    // Priority MC > BR > LH, and nothing without x_valid_i
    step("pri0",    1'b1, 7'b1111000, 6'b111000, 3'd0, 32'd14);
    step("pri1",    1'b1, 7'b0000100, 6'b000000, 3'd3, 32'd15);
    step("pri2",    1'b1, 7'b1110000, 6'b000101, 3'd0, 32'd15);
    step("pri3",    1'b1, 7'b0000000, 6'b000100, 3'd2, 32'd15);
    step("novalid", 1'b1, 7'b0111000, 6'b000000, 3'd0, 32'd15);

    // Preload the counter near saturation
    @(negedge clk_i);
    force dut.stall_count = 32'hFFFF_FFFD;
    #1;
    release dut.stall_count;

    step("sat0",    1'b1, 7'b0000010, 6'b111000, 3'd0, 32'hFFFF_FFFD);
    step("sat1",    1'b1, 7'b0000010, 6'b111000, 3'd4, 32'hFFFF_FFFE);
    step("sat2",    1'b1, 7'b0000010, 6'b111000, 3'd4, 32'hFFFF_FFFF);
    step("satclr",  1'b1, 7'b0000011, 6'b111000, 3'd4, 32'hFFFF_FFFF);
    step("sat4",    1'b1, 7'b0000000, 6'b000000, 3'd4, 32'd0);
    step("sat5",    1'b1, 7'b0000000, 6'b000000, 3'd0, 32'd0);
    // Reset asserted mid-MC_WAIT clears everything at once
    step("rmc0",    1'b1, 7'b1001000, 6'b111000, 3'd0, 32'd0);
    step("rmc1",    1'b1, 7'b0000000, 6'b111000, 3'd3, 32'd1);
    step("rmcrst",  1'b0, 7'b1111010, 6'b000000, 3'd0, 32'd0);
    step("rmcrel",  1'b1, 7'b0000000, 6'b000000, 3'd0, 32'd0);
    step("rmcrun",  1'b1, 7'b0000000, 6'b000000, 3'd0, 32'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk_i);
    end
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
